// File: rtl/mac_filter_pkg.sv
// Shared types and constants for the destination-MAC filter.
// MAC_FILTER_BROADCAST_EN also accepts frames sent to BCAST_MAC.
package mac_filter_pkg;

  typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

  localparam int MAC_LEN = 6;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef logic [2:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(MAC_LEN - 1);

  // Byte 0 of a MAC address is its most significant octet on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input byte_idx_t idx);
    logic [47:0] shifted;
    shifted = mac << (8 * idx);
    return shifted[47:40];
  endfunction

endpackage

// File: rtl/mac_hdr_buffer.sv
// Six-byte destination-MAC store with a running per-byte compare.
// MAC_FILTER_BROADCAST_EN adds FF:FF:FF:FF:FF:FF as a second accepted address.
module mac_hdr_buffer
  import mac_filter_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'hDEADBEEF1234
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      wr_en,
  input  logic [7:0] wr_data,
  input  byte_idx_t rd_idx,
  output logic [7:0] rd_data,
  output logic      done,
  output logic      match
);

  logic [7:0] hdr_buf [MAC_LEN];
  byte_idx_t  count;
  logic       addr_ok;
  logic       addr_hit;
  logic       frame_hit;

  assign addr_hit = addr_ok && (wr_data == mac_byte(MAC_ADDR, count));
  assign done     = wr_en && (count == LAST_IDX);
  assign match    = frame_hit;
  assign rd_data  = hdr_buf[rd_idx];

`ifdef MAC_FILTER_BROADCAST_EN
  logic bc_ok;
  logic bc_hit;

  assign bc_hit    = bc_ok && (wr_data == mac_byte(BCAST_MAC, count));
  assign frame_hit = addr_hit || bc_hit;

  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      bc_ok <= 1'b1;
    end else if (wr_en) begin
      bc_ok <= bc_hit;
    end
  end
`else
  assign frame_hit = addr_hit;
`endif

  // Completing or abandoning a header rewinds the store for the next frame.
  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      count   <= '0;
      addr_ok <= 1'b1;
    end else if (wr_en) begin
      count   <= count + 3'd1;
      addr_ok <= addr_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      hdr_buf[count] <= wr_data;
    end
  end

endmodule

// File: rtl/mac_filter.sv
// Destination-MAC filter on a byte-per-beat AXI-Stream path: forwards matching frames, drops others.
// MAC_FILTER_BROADCAST_EN (see mac_hdr_buffer) also forwards broadcast frames.
module mac_filter
  import mac_filter_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [47:0] MAC_ADDR = 48'hDEADBEEF1234
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tlast,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast
);

  state_t    state;
  state_t    state_next;
  byte_idx_t rep_idx;
  logic      rep_last;
  logic      hdr_wr;
  logic      hdr_clear;
  logic      hdr_done;
  logic      hdr_match;
  logic [7:0] rd_data;
  logic      unused_upper;

  assign unused_upper = ^in_tdata[DATA_W-1:8];

  mac_hdr_buffer #(
    .MAC_ADDR(MAC_ADDR)
  ) u_hdr (
    .clk     (clk),
    .rst     (rst),
    .clear   (hdr_clear),
    .wr_en   (hdr_wr),
    .wr_data (in_tdata[7:0]),
    .rd_idx  (rep_idx),
    .rd_data (rd_data),
    .done    (hdr_done),
    .match   (hdr_match)
  );

  // rep_last remembers a frame that ended on its 6th byte, so replay closes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR;
      rep_idx  <= '0;
      rep_last <= 1'b0;
    end else begin
      state <= state_next;
      if (hdr_done) begin
        rep_idx  <= '0;
        rep_last <= in_tlast;
      end else if (state == REPLAY && out_tready) begin
        rep_idx <= rep_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tlast  = 1'b0;
    hdr_wr     = 1'b0;
    hdr_clear  = 1'b0;
    if (!rst) begin
      case (state)
        HDR: begin
          in_tready = 1'b1;
          if (in_tvalid) begin
            hdr_wr = 1'b1;
            if (hdr_done) begin
              if (hdr_match) begin
                state_next = REPLAY;
              end else if (!in_tlast) begin
                state_next = DROP;
              end
            end else if (in_tlast) begin
              hdr_clear = 1'b1;
            end
          end
        end
        REPLAY: begin
          out_tvalid = 1'b1;
          out_tdata  = {{(DATA_W-8){1'b0}}, rd_data};
          out_tlast  = rep_last && (rep_idx == LAST_IDX);
          if (out_tready && rep_idx == LAST_IDX) begin
            state_next = rep_last ? HDR : PASS;
          end
        end
        PASS: begin
          out_tvalid = in_tvalid;
          in_tready  = out_tready;
          out_tdata  = {{(DATA_W-8){1'b0}}, in_tdata[7:0]};
          out_tlast  = in_tlast;
          if (in_tvalid && out_tready && in_tlast) begin
            state_next = HDR;
          end
        end
        DROP: begin
          in_tready = 1'b1;
          if (in_tvalid && in_tlast) begin
            state_next = HDR;
          end
        end
        default: state_next = HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_filter.sv
// Directed self-checking bench for mac_filter; honours MAC_FILTER_BROADCAST_EN for the broadcast case.
module tb_mac_filter;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_tvalid;
  logic              in_tready;
  logic [DATA_W-1:0] in_tdata;
  logic              in_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic [DATA_W-1:0] out_tdata;
  logic              out_tlast;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] cap_q[$];
  bit          toggle_mode = 1'b0;
  bit          all_ready   = 1'b1;
  bit          stalled     = 1'b0;
  logic [32:0] held;

  mac_filter #(
    .DATA_W  (DATA_W),
    .MAC_ADDR(48'hDEADBEEF1234)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tlast  (in_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata (out_tdata),
    .out_tlast (out_tlast)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Capture every output handshake and verify held beats stay put while stalled.
  always @(negedge clk) begin
    if (stalled) begin
      checkOutput("stall_hold", {30'd0, out_tvalid, out_tlast, out_tdata}, {30'd0, 1'b1, held});
    end
    if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
      cap_q.push_back({out_tlast, out_tdata});
    end
    stalled = (out_tvalid === 1'b1) && (out_tready !== 1'b1);
    held    = {out_tlast, out_tdata};
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    out_tready = toggle_mode ? ~out_tready : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic applyStimulus(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      bit done = 1'b0;
      bit hs;
      in_tvalid = 1'b1;
      in_tdata  = {24'hC3A55A, tx_q[i]};
      in_tlast  = with_last && (i == n - 1);
      while (!done) begin
        @(negedge clk);
        hs = in_tready;
        if (!hs) all_ready = 1'b0;
        stepCycle();
        if (hs) begin
          done = 1'b1;
        end else if (++waited > 100) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: byte %0d not accepted, required acceptance within 100 cycles", i);
          done = 1'b1;
        end
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tdata  = '0;
  endtask

  task automatic expectForward();
    exp_q.delete();
    foreach (tx_q[i]) exp_q.push_back({(i == tx_q.size() - 1), 24'h0, tx_q[i]});
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", tag, i), {31'd0, cap_q[i]}, {31'd0, exp_q[i]});
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic loadGood();
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35, 8'h12,
             8'h34, 8'h56, 8'h08, 8'h00, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_tvalid"}, {63'd0, out_tvalid}, 64'd0);
    checkOutput({tag, "_out_tlast"},  {63'd0, out_tlast},  64'd0);
    checkOutput({tag, "_out_tdata"},  {32'd0, out_tdata},  64'd0);
    checkOutput({tag, "_in_tready"},  {63'd0, in_tready},  64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    $display("[TB] good frame, out_tready high");
    loadGood();
    applyStimulus(19, 1'b1);
    idle(20);
    expectForward();
    checkFrame("t1");

    $display("[TB] wrong destination, then good frame");
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h0A, 8'h35, 8'h12,
             8'h34, 8'h56, 8'h08, 8'h00, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    all_ready = 1'b1;
    applyStimulus(19, 1'b1);
    checkOutput("t2_in_tready_always", {63'd0, all_ready}, 64'd1);
    idle(5);
    exp_q.delete();
    checkFrame("t2_drop");
    loadGood();
    applyStimulus(19, 1'b1);
    idle(20);
    expectForward();
    checkFrame("t2_next");

    $display("[TB] good frame, out_tready toggling");
    toggle_mode = 1'b1;
    loadGood();
    applyStimulus(19, 1'b1);
    idle(40);
    expectForward();
    checkFrame("t3");
    toggle_mode = 1'b0;
    out_tready  = 1'b1;

    $display("[TB] runt then good frame back-to-back");
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus(4, 1'b1);
    loadGood();
    applyStimulus(19, 1'b1);
    idle(20);
    expectForward();
    checkFrame("t4");

    $display("[TB] reset mid-frame");
    loadGood();
    applyStimulus(10, 1'b0);
    rst = 1'b1;
    #2;
    checkResetOutputs("t5_in_reset");
    stepCycle();
    stepCycle();
    checkResetOutputs("t5_held_reset");
    rst = 1'b0;
    cap_q.delete();
    applyStimulus(19, 1'b1);
    idle(20);
    expectForward();
    checkFrame("t5");

    $display("[TB] broadcast destination");
    tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h0A, 8'h35, 8'h12,
             8'h08, 8'h00, 8'h48, 8'h69};
    applyStimulus(14, 1'b1);
    idle(20);
`ifdef MAC_FILTER_BROADCAST_EN
    expectForward();
`else
    exp_q.delete();
`endif
    checkFrame("t6");

    $display("[TB] exactly-6-byte frames");
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    applyStimulus(6, 1'b1);
    idle(15);
    expectForward();
    checkFrame("t7_match6");
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h35};
    applyStimulus(6, 1'b1);
    loadGood();
    applyStimulus(19, 1'b1);
    idle(20);
    expectForward();
    checkFrame("t7_miss6_then_good");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
